// File: rtl/accumulator_divider.sv
// accumulator_divider
// Sequential unsigned restoring divider. It computes one quotient bit per
// clock, MSB first, so an N-bit division takes N cycles in RUN.
//
// Optional feature macro: DIV_BY_ZERO_FLAG_EN. When it is defined, the block
// adds a div_by_zero output. A start with divisor 0 then finishes after a
// single cycle instead of running all N steps.
//
// Ports
//   clock        single clock, rising edge
//   reset        synchronous, active-high
//   start        request a division (only honoured in IDLE or DONE)
//   dividend     N-bit unsigned dividend, captured on the accepted start
//   divisor      N-bit unsigned divisor, captured on the accepted start
//   quotient     N-bit result of the last completed operation
//   remainder    N-bit result of the last completed operation
//   busy         high while in RUN
//   done         high while in DONE
//   div_by_zero  (DIV_BY_ZERO_FLAG_EN only) last accepted operation had divisor 0
//
// state | meaning
// IDLE  | after reset, no result yet
// RUN   | one restoring step per cycle, counter counts down from N
// DONE  | quotient/remainder valid, waiting for next start
module accumulator_divider #(
   parameter int N = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         busy,
   output logic         done
`ifdef DIV_BY_ZERO_FLAG_EN
   ,
   output logic         div_by_zero
`endif
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [N-1:0]  dvd;       // dividend bits shift out as quotient bits shift in
   logic [N-1:0]  dvs;
   logic [N-1:0]  rem;
   logic [CW-1:0] cnt;

   logic [N:0]    shifted;
   logic          neg;
   logic [N-1:0]  diff;
   logic [N-1:0]  rem_next;
   logic          q_bit;

   // The comparison is done at N+1 bits. The difference only has to be N
   // bits wide because a non-negative trial result is always below the
   // divisor. With a zero divisor the difference equals shifted modulo 2^N,
   // so the dividend accumulates into the remainder.
   always_comb begin
      shifted  = {rem, dvd[N-1]};
      neg      = shifted < {1'b0, dvs};
      diff     = shifted[N-1:0] - dvs;
      rem_next = neg ? shifted[N-1:0] : diff;
      q_bit    = ~neg;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         dvd       <= '0;
         dvs       <= '0;
         rem       <= '0;
         cnt       <= '0;
         quotient  <= '0;
         remainder <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef DIV_BY_ZERO_FLAG_EN
         div_by_zero <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  dvd   <= dividend;
                  dvs   <= divisor;
                  rem   <= '0;
                  cnt   <= CW'(N);
                  state <= RUN;
                  busy  <= 1'b1;
                  done  <= 1'b0;
`ifdef DIV_BY_ZERO_FLAG_EN
                  div_by_zero <= 1'b0;
                  // A zero divisor spends a single cycle in RUN and then
                  // completes on the next edge.
                  if (divisor == '0) cnt <= CW'(1);
`endif
               end
            end
            RUN: begin
               rem <= rem_next;
               dvd <= {dvd[N-2:0], q_bit};
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  quotient  <= {dvd[N-2:0], q_bit};
                  remainder <= rem_next;
`ifdef DIV_BY_ZERO_FLAG_EN
                  // Only one step has run, so dvd still holds the captured dividend.
                  if (dvs == '0) begin
                     quotient    <= '1;
                     remainder   <= dvd;
                     div_by_zero <= 1'b1;
                  end
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/accumulator_divider.md
ACCUMULATOR_DIVIDER -- requirements
Module: accumulator_divider

Interface
REQ-001 SHALL have parameter N, default 32, operand and result width in bits (N >= 2).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a division; sampled only in IDLE or DONE.
REQ-005 SHALL have port dividend  input  N  unsigned dividend, sampled on the accepted start edge.
REQ-006 SHALL have port divisor  input  N  unsigned divisor, sampled on the accepted start edge.
REQ-007 SHALL have port quotient  output  N  unsigned quotient of the last completed operation.
REQ-008 SHALL have port remainder  output  N  unsigned remainder of the last completed operation.
REQ-009 SHALL have port busy  output  1  high while in RUN.
REQ-010 SHALL have port done  output  1  high while in DONE; results valid.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 SHALL, on a rising edge with start=1 in IDLE or DONE, capture dividend and divisor, clear the working remainder, load a step counter with N, and enter RUN.
REQ-013 SHALL ignore start while in RUN; operands held internally are not disturbed by input changes.
REQ-014 SHALL perform one restoring-division step per RUN cycle, MSB first: shift {rem, dividend bit} left by 1, trial-subtract divisor using N+1-bit arithmetic, keep the difference and set the quotient bit to 1 if non-negative, else restore and set it to 0.
REQ-015 SHALL complete N steps on edges t0+1 .. t0+N after accepting start at edge t0, load quotient/remainder on edge t0+N, and enter DONE, so done is first high N cycles after the accepted start edge.
REQ-016 SHALL hold quotient and remainder stable from completion until the next completion or reset; they SHALL NOT show intermediate values during RUN.
REQ-017 SHALL remain in DONE, done=1, until start (returns to RUN, done falls next cycle) or reset.
REQ-018 SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for every divisor != 0.
REQ-019 SHALL, for divisor == 0 without the macro, run the normal N steps and produce quotient = all ones, remainder = dividend.
REQ-020 SHALL keep busy and done mutually exclusive; both low in IDLE.

Reset
REQ-021 SHALL, when reset=1 at a rising edge, enter IDLE and set quotient=0, remainder=0, busy=0, done=0, counter=0, regardless of state, including mid-RUN (operation abandoned, no result written).
REQ-022 SHALL give reset priority over start on the same edge.

Configuration
REQ-023 SHALL support macro DIV_BY_ZERO_FLAG_EN.
REQ-024 With DIV_BY_ZERO_FLAG_EN defined: SHALL add output div_by_zero (1 bit, reset 0); an accepted start with divisor=0 SHALL go directly to DONE on the next edge (done high one cycle after start edge) with quotient=all ones, remainder=dividend, div_by_zero=1; div_by_zero SHALL clear on the next accepted start or reset.
REQ-025 Without DIV_BY_ZERO_FLAG_EN: SHALL have no div_by_zero port; divide-by-zero behaves per REQ-019 with full N-cycle latency.

Verification (N=32)
REQ-026 Reset 2 cycles, then start with 100/7 -> done rises exactly 32 cycles after start edge; quotient=14, remainder=2; busy high for those 32 cycles.
REQ-027 Back-to-back: 0/1 then 0xFFFFFFFF/1 then 7/7, each started from DONE -> (0,0), (0xFFFFFFFF,0), (1,0); done drops one cycle after each start.
REQ-028 Start 10586/79, toggle start and change operands at cycle 5 of RUN -> ignored; quotient=134, remainder=0 at done.
REQ-029 Start 127/3, assert reset at cycle 10 of RUN -> next cycle IDLE, quotient=0, remainder=0, busy=0, done=0; a fresh 127/3 then yields 42 r1.
REQ-030 Start 5/0 -> quotient=0xFFFFFFFF, remainder=5; without macro done after 32 cycles; with DIV_BY_ZERO_FLAG_EN done after 1 cycle and div_by_zero=1, cleared by next start with 9/2 (4 r1).
REQ-031 Random 1000 operand pairs with divisor != 0 -> REQ-018 holds for each, checked against a reference model.
